// File: rtl/spi_pkg.sv
// Shared state encoding and parameter-derived sizing helpers for the SPI shift engine.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_DONE
  } spi_state_t;

  // SCLK period in system clocks.
  function automatic int unsigned clk_period(input int unsigned ndivbits);
    return 32'd1 << ndivbits;
  endfunction

  // SCLK half-period in system clocks.
  function automatic int unsigned clk_half(input int unsigned ndivbits);
    return 32'd1 << (ndivbits - 1);
  endfunction

  function automatic int unsigned bitcnt_width(input int unsigned nbits);
    return $clog2(nbits + 1);
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Power-of-two SCLK divider: free-running counter with half- and full-period strobes.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int unsigned NCLKDIVBITS = 5
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic restart,
  output logic half_tick,
  output logic period_tick
);

  localparam int unsigned H = clk_half(NCLKDIVBITS);

  logic [NCLKDIVBITS-1:0] cnt;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + NCLKDIVBITS'(1);
    end
  end

  assign half_tick   = (cnt == NCLKDIVBITS'(H - 1));
  assign period_tick = (cnt == '1);

endmodule

// File: rtl/spi_shift_engine.sv
// SPI frame engine: turns a trigger pulse and parallel word into one MSB-first frame,
// captures MISO into dout and holds dvld until acknowledged.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int unsigned NBITS        = 24,
  parameter int unsigned NCLKDIVBITS  = 5,
  parameter logic        INVERT_CLOCK = 1'b0,
  parameter int unsigned NCSBITS      = 3
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [NCSBITS-1:0] cs_in,
  input  logic [NCSBITS-1:0] cs_in_idle,
  input  logic [NBITS-1:0]   din,
  input  logic               trigger,
  input  logic               ack,
  output logic [NBITS-1:0]   dout,
  output logic               dvld,
  output logic               busy,
  output logic [NCSBITS-1:0] cs,
  output logic               sclk,
  output logic               mosi,
  input  logic               miso
);

  localparam int unsigned       BCW      = bitcnt_width(NBITS);
  localparam logic [BCW-1:0]    LAST_BIT = BCW'(NBITS - 1);

  spi_state_t       state;
  logic [NBITS-1:0] tx_sr;
  logic [NBITS-1:0] tx_next;
  logic [NBITS-1:0] rx_sr;
  logic [BCW-1:0]   bit_cnt;
  logic             sclk_int;
  logic             half_tick;
  logic             period_tick;
  logic             div_restart;

  // Divider is held at zero while waiting, so every busy state starts at count 0;
  // all other transitions land exactly on the natural wrap.
  assign div_restart = (state == ST_IDLE) || (state == ST_DONE);
  assign tx_next     = tx_sr << 1;
  assign sclk        = sclk_int ^ INVERT_CLOCK;

  spi_clk_div #(
    .NCLKDIVBITS(NCLKDIVBITS)
  ) u_clk_div (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .restart    (div_restart),
    .half_tick  (half_tick),
    .period_tick(period_tick)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= ST_IDLE;
      tx_sr    <= '0;
      rx_sr    <= '0;
      bit_cnt  <= '0;
      sclk_int <= 1'b0;
      cs       <= '1;
      mosi     <= 1'b0;
      dout     <= '0;
      dvld     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (trigger) begin
            state    <= ST_SETUP;
            tx_sr    <= din;
            rx_sr    <= '0;
            bit_cnt  <= '0;
            sclk_int <= 1'b0;
            cs       <= cs_in;
            mosi     <= din[NBITS-1];
            busy     <= 1'b1;
            dvld     <= 1'b0;
          end else begin
            cs <= cs_in_idle;
            if (ack && (state == ST_DONE)) begin
              dvld  <= 1'b0;
              state <= ST_IDLE;
            end
          end
        end

        ST_SETUP: begin
          if (period_tick) begin
            state <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (half_tick) begin
            sclk_int <= 1'b1;
            rx_sr    <= (rx_sr << 1) | NBITS'(miso);
          end
          if (period_tick) begin
            sclk_int <= 1'b0;
            if (bit_cnt == LAST_BIT) begin
              state <= ST_HOLD;
            end else begin
              bit_cnt <= bit_cnt + BCW'(1);
              tx_sr   <= tx_next;
              mosi    <= tx_next[NBITS-1];
            end
          end
        end

        ST_HOLD: begin
          if (period_tick) begin
            state <= ST_DONE;
            dout  <= rx_sr;
            dvld  <= 1'b1;
            busy  <= 1'b0;
            cs    <= cs_in_idle;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: normal and inverted-clock instances, random frames
// checked cycle by cycle against an arithmetic timing/data model.
module tb_spi_shift_engine;

  localparam int NB    = 24;
  localparam int D     = 32;
  localparam int H     = 16;
  localparam int END_C = 1 + D * (NB + 2);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  cs_in = '0;
  logic [2:0]  cs_in_idle = 3'b111;
  logic [23:0] din = '0;
  logic        trigger = 1'b0;
  logic        ack = 1'b0;
  logic        loopback = 1'b1;
  logic        miso_drv = 1'b0;
  logic        miso;

  logic [23:0] dout, dout_i;
  logic        dvld, dvld_i, busy, busy_i, sclk, sclk_i, mosi, mosi_i;
  logic [2:0]  cs, cs_o_i;

  int checks = 0;
  int passes = 0;

  logic [23:0] model_dout   = '0;
  logic [23:0] model_dout_i = '0;

  int          bad[9];
  int          first_c[9];
  logic [31:0] got[9];
  logic [31:0] expv[9];
  string       cat_name[9] = '{"cs", "busy", "dvld", "mosi", "sclk", "sclk_inv",
                               "edge_pos", "dout", "dout_inv"};

  assign miso = loopback ? mosi : miso_drv;

  always #5 clk = ~clk;

  spi_shift_engine #(
    .NBITS(24), .NCLKDIVBITS(5), .INVERT_CLOCK(1'b0), .NCSBITS(3)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .cs_in(cs_in), .cs_in_idle(cs_in_idle),
    .din(din), .trigger(trigger), .ack(ack), .dout(dout), .dvld(dvld),
    .busy(busy), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  spi_shift_engine #(
    .NBITS(24), .NCLKDIVBITS(5), .INVERT_CLOCK(1'b1), .NCSBITS(3)
  ) dut_inv (
    .wb_clk_i(clk), .wb_rst_i(rst), .cs_in(cs_in), .cs_in_idle(cs_in_idle),
    .din(din), .trigger(trigger), .ack(ack), .dout(dout_i), .dvld(dvld_i),
    .busy(busy_i), .cs(cs_o_i), .sclk(sclk_i), .mosi(mosi_i), .miso(mosi_i)
  );

  task automatic note(input int cat, input int c, input logic [31:0] g, input logic [31:0] e);
    if (bad[cat] == 0) begin
      first_c[cat] = c;
      got[cat]     = g;
      expv[cat]    = e;
    end
    bad[cat]++;
  endtask

  // One full frame from trigger (cycle 0) to `last`, every cycle compared with the model.
  task automatic run_frame(input string tag, input logic [23:0] d, input logic [2:0] ca,
                           input bit loop, input logic [23:0] sw, input int trig2,
                           input int ack_c, input bit ack_with_trig);
    int          last, k, ph, k2, ph2, rises, falls_i;
    bit          in_frame, in_shift, exp_sclk, exp_dvld;
    logic        prev_sclk, prev_sclki;
    logic [23:0] exp_word, exp_dout, exp_dout_i;
    for (int i = 0; i < 9; i++) bad[i] = 0;
    exp_word = loop ? d : sw;
    last     = (ack_c >= END_C) ? ack_c + 2 : END_C + 2;
    rises    = 0;
    falls_i  = 0;
    loopback = loop;
    @(negedge clk);
    din = d; cs_in = ca; trigger = 1'b1; ack = ack_with_trig; miso_drv = 1'($urandom);
    prev_sclk  = sclk;
    prev_sclki = sclk_i;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      trigger = (c == trig2);
      ack     = (c == ack_c);
      din     = 24'($urandom);
      cs_in   = 3'($urandom);
      k2  = (c - D) / D;
      ph2 = (c - D) % D;
      if (c >= D && k2 < NB && ph2 == H) miso_drv = sw[23 - k2];
      else                               miso_drv = 1'($urandom);

      in_frame = (c < END_C);
      in_shift = (c >= 1 + D) && (c <= D * (NB + 1));
      k  = (c - 1 - D) / D;
      ph = (c - 1 - D) % D;
      exp_sclk = in_shift && (ph >= H);
      exp_dvld = (c >= END_C) && (ack_c == 0 || c <= ack_c);
      exp_dout   = (c >= END_C) ? exp_word : model_dout;
      exp_dout_i = (c >= END_C) ? d : model_dout_i;

      if (cs !== (in_frame ? ca : cs_in_idle)) note(0, c, 32'(cs), 32'(in_frame ? ca : cs_in_idle));
      if (busy !== in_frame) note(1, c, 32'(busy), 32'(in_frame));
      if (dvld !== exp_dvld) note(2, c, 32'(dvld), 32'(exp_dvld));
      if (c <= D) begin
        if (mosi !== d[23]) note(3, c, 32'(mosi), 32'(d[23]));
      end else if (in_shift) begin
        if (mosi !== d[23 - k]) note(3, c, 32'(mosi), 32'(d[23 - k]));
      end
      if (sclk !== exp_sclk) note(4, c, 32'(sclk), 32'(exp_sclk));
      if (sclk_i !== !exp_sclk) note(5, c, 32'(sclk_i), 32'(!exp_sclk));
      if (!prev_sclk && sclk) begin
        rises++;
        if (!(in_shift && ph == H)) note(6, c, 32'(ph), 32'(H));
      end
      if (prev_sclki && !sclk_i) begin
        falls_i++;
        if (!(in_shift && ph == H)) note(6, c, 32'(ph), 32'(H));
      end
      if (dout !== exp_dout) note(7, c, 32'(dout), 32'(exp_dout));
      if (dout_i !== exp_dout_i) note(8, c, 32'(dout_i), 32'(exp_dout_i));
      prev_sclk  = sclk;
      prev_sclki = sclk_i;
    end
    trigger = 1'b0;
    ack     = 1'b0;
    model_dout   = exp_word;
    model_dout_i = d;

    for (int i = 0; i < 9; i++) begin
      checks++;
      if (bad[i] == 0) passes++;
      else $display("FAIL %s %s: %0d bad cycles, first at cycle %0d got %h required %h",
                    tag, cat_name[i], bad[i], first_c[i], got[i], expv[i]);
    end
    checks++;
    if (rises == NB) passes++;
    else $display("FAIL %s sclk_rises: got %0d required %0d", tag, rises, NB);
    checks++;
    if (falls_i == NB) passes++;
    else $display("FAIL %s sclk_inv_falls: got %0d required %0d", tag, falls_i, NB);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({cs, sclk, sclk_i, mosi, dvld, busy} === {3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) passes++;
    else $display("FAIL reset_ctrl: got cs=%b sclk=%b sclk_inv=%b mosi=%b dvld=%b busy=%b required 111 0 1 0 0 0",
                  cs, sclk, sclk_i, mosi, dvld, busy);
    checks++;
    if (dout === 24'h0 && dout_i === 24'h0) passes++;
    else $display("FAIL reset_dout: got %h/%h required 000000", dout, dout_i);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_loopback();
    run_frame("loopback", 24'hA5C33C, 3'b110, 1'b1, 24'h0, 0, 840, 1'b0);
  endtask

  task automatic test_slave();
    run_frame("slave", 24'($urandom), 3'b101, 1'b0, 24'h5A0F81, 0, 850, 1'b0);
  endtask

  task automatic test_ignored_trigger();
    run_frame("ignored_trigger", 24'($urandom), 3'b011, 1'b1, 24'h0, 400, 845, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_frame("done_retrigger_a", 24'($urandom), 3'b110, 1'b0, 24'($urandom), 0, 0, 1'b0);
    run_frame("done_retrigger_b", 24'($urandom), 3'b100, 1'b1, 24'h0, 0, 0, 1'b0);
    run_frame("trigger_with_ack", 24'($urandom), 3'b101, 1'b0, 24'($urandom), 0, END_C + 3, 1'b1);
  endtask

  task automatic test_ack_idle();
    logic [2:0] v;
    v = 3'($urandom);
    @(negedge clk);
    ack = 1'b1;
    cs_in_idle = v;
    @(negedge clk);
    ack = 1'b0;
    checks++;
    if (dvld === 1'b0 && busy === 1'b0 && cs === v && dout === model_dout) passes++;
    else $display("FAIL ack_idle: got dvld=%b busy=%b cs=%b dout=%h required 0 0 %b %h",
                  dvld, busy, cs, dout, v, model_dout);
    cs_in_idle = 3'b111;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    bit lp;
    for (int n = 0; n < 3; n++) begin
      lp = 1'($urandom);
      run_frame("random", 24'($urandom), 3'($urandom), lp, 24'($urandom), 0,
                END_C + int'($urandom_range(0, 10)), 1'b0);
    end
  endtask

  task automatic test_reset_midframe();
    @(negedge clk);
    din = 24'h3C5A96; cs_in = 3'b010; trigger = 1'b1; loopback = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      trigger = 1'b0;
    end
    checks++;
    if (busy === 1'b1 && cs === 3'b010) passes++;
    else $display("FAIL pre_reset_busy: got busy=%b cs=%b required 1 010", busy, cs);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({cs, sclk, sclk_i, mosi, busy, dvld} === {3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) passes++;
    else $display("FAIL async_reset_ctrl: got cs=%b sclk=%b sclk_inv=%b mosi=%b busy=%b dvld=%b required 111 0 1 0 0 0",
                  cs, sclk, sclk_i, mosi, busy, dvld);
    checks++;
    if (dout === 24'h0 && dout_i === 24'h0) passes++;
    else $display("FAIL async_reset_dout: got %h/%h required 000000", dout, dout_i);
    model_dout   = '0;
    model_dout_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_frame("after_reset", 24'($urandom), 3'b001, 1'b0, 24'($urandom), 0, END_C + 2, 1'b0);
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_slave();
    test_ignored_trigger();
    test_back_to_back();
    test_ack_idle();
    test_random();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
